axi4_lite_slave_regfile: RTL

//  AXI4-Lite responder: NUM_REGS x DATA_WIDTH register file, full AW/W/B/AR/R handshakes, OKAY/SLVERR responses.

---
 rtl/axi4_lite_slave_regfile_if.sv | 41 ++++
 rtl/axi4_lite_slave_regfile.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_slave_regfile_if.sv
// AXI4-Lite bus bundle between a master and the register-file responder.
// Signals:
//   aw: awaddr, awvalid (m->s), awready (s->m)
//   w : wdata, wstrb, wvalid (m->s), wready (s->m)
//   b : bresp, bvalid (s->m), bready (m->s)
//   ar: araddr, arvalid (m->s), arready (s->m)
//   r : rdata, rresp, rvalid (s->m), rready (m->s)
interface axi4_lite_slave_regfile_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_W-1:0]     wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite responder backed by a NUM_REGS x DATA_WIDTH register file.
// Ports:
//   aclk   - clock, everything on the rising edge
//   areset - synchronous active-high reset
//   bus    - axi4_lite_slave_regfile_if.slave (AW/W/B/AR/R channels)
// Independent write and read FSMs; all outputs registered. Out-of-range word
// index answers SLVERR (reads return 0). Address bits below the byte-lane
// count are ignored.
// Optional feature: define AXI4_LITE_SLAVE_ID_REG_EN to make register 0 a
// read-only ID register returning ID_VALUE; writes to it answer SLVERR.
module axi4_lite_slave_regfile #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16,
  parameter logic [31:0] ID_VALUE   = 32'hA411_0001
) (
  input logic                      aclk,
  input logic                      areset,
  axi4_lite_slave_regfile_if.slave bus
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFFS   = $clog2(STRB_W);
  localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic {StIdle, StResp} state_e;

  function automatic logic in_range(logic [ADDR_WIDTH-1:0] a);
    return (a >> OFFS) < ADDR_WIDTH'(NUM_REGS);
  endfunction

  function automatic logic [IDX_W-1:0] to_idx(logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] w;
    w = a >> OFFS;
    return w[IDX_W-1:0];
  endfunction

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Write channel state
  state_e                wstate;
  logic                  aw_got, w_got;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  logic                  awready_q, wready_q, bvalid_q;
  logic [1:0]            bresp_q;
  logic                  w_ok;

  // Read channel state
  state_e                rstate;
  logic                  arready_q, rvalid_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  always_comb begin
    w_ok = in_range(aw_addr);
`ifdef AXI4_LITE_SLAVE_ID_REG_EN
    if (to_idx(aw_addr) == '0) w_ok = 1'b0;
`endif
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wstate    <= StIdle;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      aw_addr   <= '0;
      w_data    <= '0;
      w_strb    <= '0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      unique case (wstate)
        StIdle: begin
          if (aw_got && w_got) begin
            // Commit cycle: both halves are held, readies already low.
            if (w_ok) begin
              for (int unsigned b = 0; b < STRB_W; b++) begin
                if (w_strb[b]) regs[to_idx(aw_addr)][8*b +: 8] <= w_data[8*b +: 8];
              end
            end
            bresp_q  <= w_ok ? 2'b00 : 2'b10;
            bvalid_q <= 1'b1;
            wstate   <= StResp;
          end else begin
            if (bus.awvalid && awready_q) begin
              aw_addr   <= bus.awaddr;
              aw_got    <= 1'b1;
              awready_q <= 1'b0;
            end
            if (bus.wvalid && wready_q) begin
              w_data   <= bus.wdata;
              w_strb   <= bus.wstrb;
              w_got    <= 1'b1;
              wready_q <= 1'b0;
            end
          end
        end
        StResp: begin
          if (bus.bready) begin
            bvalid_q  <= 1'b0;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wstate    <= StIdle;
          end
        end
        default: wstate <= StIdle;
      endcase
    end
  end

  // Reads sample regs before any same-edge commit lands (pre-write value).
  always_ff @(posedge aclk) begin
    if (areset) begin
      rstate    <= StIdle;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
    end else begin
      unique case (rstate)
        StIdle: begin
          if (bus.arvalid && arready_q) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rstate    <= StResp;
            if (!in_range(bus.araddr)) begin
              rdata_q <= '0;
              rresp_q <= 2'b10;
            end
`ifdef AXI4_LITE_SLAVE_ID_REG_EN
            else if (to_idx(bus.araddr) == '0) begin
              rdata_q <= DATA_WIDTH'(ID_VALUE);
              rresp_q <= 2'b00;
            end
`endif
            else begin
              rdata_q <= regs[to_idx(bus.araddr)];
              rresp_q <= 2'b00;
            end
          end
        end
        StResp: begin
          if (bus.rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rstate    <= StIdle;
          end
        end
        default: rstate <= StIdle;
      endcase
    end
  end

  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rresp   = rresp_q;
  assign bus.rdata   = rdata_q;
endmodule
